mmio_intr_ctrl: RTL and testbench

- Memory-mapped interrupt controller on the IOBUS, clocked on the CPU clock.
- Latches rising edges from up to N_SRC event sources (debounced button pulses, timers) into a pending register.
- Applies a software-writable mask and drives the single CPU interrupt line through a sequenced assert/acknowledge handshake.
- The CPU reads the pending register and the highest-priority source ID, then acknowledges by write-1-to-clear.

---
 rtl/mmio_intr_ctrl.sv | 135 +++++++++++++
 tb/tb_mmio_intr_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_intr_ctrl.sv
// MMIO interrupt controller: edge-latched pending bits, software mask,
// fixed lowest-index priority and a held INTR pulse per request.
module mmio_intr_ctrl #(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_AD   = 32'h11000060,
    parameter int          INTR_HOLD = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_SRC-1:0] SRC,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    output logic [31:0]      IOBUS_IN,
    output logic             INTR,
    output logic             BUSY
);

    localparam int IDW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [31:0] A_PEND = BASE_AD;
    localparam logic [31:0] A_MASK = BASE_AD + 32'd4;
    localparam logic [31:0] A_ID   = BASE_AD + 32'd8;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WAIT_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] src_q, src_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [IDW-1:0]   cur_id_q, cur_id_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             intr_q, intr_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] req;
    logic [IDW-1:0]   pri_id;

    assign rise = SRC & ~src_q;
    assign req  = pend_q & mask_q;

    always_comb begin
        src_d  = SRC;
        clr    = '0;
        mask_d = mask_q;
        if (IOBUS_WR && IOBUS_ADDR == A_PEND) begin
            clr = IOBUS_OUT[N_SRC-1:0];
        end
        if (IOBUS_WR && IOBUS_ADDR == A_MASK) begin
            mask_d = IOBUS_OUT[N_SRC-1:0];
        end
        // OR-ing rise last lets a same-cycle set beat the clear
        pend_d = (pend_q & ~clr) | rise;
    end

    // Walk downward so the lowest set index is the last one written
    always_comb begin
        pri_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                pri_id = IDW'(i);
            end
        end
    end

    always_comb begin
        IOBUS_IN = 32'd0;
        if (IOBUS_ADDR == A_PEND) begin
            IOBUS_IN = 32'(pend_q);
        end else if (IOBUS_ADDR == A_MASK) begin
            IOBUS_IN = 32'(mask_q);
        end else if (IOBUS_ADDR == A_ID) begin
            IOBUS_IN = (|req) ? 32'(pri_id) : 32'hFFFF_FFFF;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_id_d = cur_id_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    cur_id_d = pri_id;
                    cnt_d    = 4'(INTR_HOLD - 1);
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (cnt_q == 4'd0) begin
                    state_d = WAIT_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WAIT_ACK: begin
                // Leave on acknowledge or when software masks the source
                if (!pend_q[cur_id_q] || !mask_q[cur_id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        intr_d = (state_d == ASSERT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            src_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            cur_id_q <= '0;
            cnt_q    <= 4'd0;
            intr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            cur_id_q <= cur_id_d;
            cnt_q    <= cnt_d;
            intr_q   <= intr_d;
        end
    end

    assign INTR = intr_q;
    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_mmio_intr_ctrl.sv
// Directed bench for mmio_intr_ctrl: a cycle table for the main
// handshake plus short sequences for masking, races and reset.
module tb_mmio_intr_ctrl;

    localparam logic [31:0] A_PEND = 32'h11000060;
    localparam logic [31:0] A_MASK = 32'h11000064;
    localparam logic [31:0] A_ID   = 32'h11000068;
    localparam logic [31:0] A_UNM  = 32'h1100006C;
    localparam logic [31:0] NONE   = 32'hFFFF_FFFF;

    logic        CLK;
    logic        RST;
    logic [3:0]  SRC;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        INTR;
    logic        BUSY;

    mmio_intr_ctrl #(
        .N_SRC(4),
        .BASE_AD(32'h11000060),
        .INTR_HOLD(2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .SRC(SRC),
        .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR),
        .IOBUS_IN(IOBUS_IN),
        .INTR(INTR),
        .BUSY(BUSY)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  src;
        logic [31:0] exp_rd;
        logic        exp_intr;
        logic        exp_busy;
    } vec_t;

    vec_t vt [0:21];
    int n_chk = 0;
    int n_fail = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s);
        IOBUS_ADDR = a;
        IOBUS_WR   = w;
        IOBUS_OUT  = d;
        SRC        = s;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a,
                          input logic [31:0] exp);
        IOBUS_ADDR = a;
        #1;
        check(nm, IOBUS_IN, exp);
    endtask

    int hi;

    initial begin
        // One cycle per row; outputs sampled mid-cycle before the edge
        vt[0]  = '{A_MASK, 1'b1, 32'hF, 4'h0, 32'h0, 1'b0, 1'b0};
        vt[1]  = '{A_PEND, 1'b0, 32'h0, 4'h4, 32'h0, 1'b0, 1'b0};
        vt[2]  = '{A_PEND, 1'b0, 32'h0, 4'h0, 32'h4, 1'b0, 1'b0};
        vt[3]  = '{A_ID,   1'b0, 32'h0, 4'h0, 32'h2, 1'b1, 1'b1};
        vt[4]  = '{A_MASK, 1'b0, 32'h0, 4'h0, 32'hF, 1'b1, 1'b1};
        vt[5]  = '{A_PEND, 1'b0, 32'h0, 4'h0, 32'h4, 1'b0, 1'b1};
        vt[6]  = '{A_PEND, 1'b1, 32'h4, 4'h0, 32'h4, 1'b0, 1'b1};
        vt[7]  = '{A_ID,   1'b0, 32'h0, 4'h0, NONE,  1'b0, 1'b1};
        vt[8]  = '{A_ID,   1'b0, 32'h0, 4'h0, NONE,  1'b0, 1'b0};
        vt[9]  = '{A_UNM,  1'b1, 32'hF, 4'h0, 32'h0, 1'b0, 1'b0};
        vt[10] = '{A_ID,   1'b0, 32'h0, 4'hA, NONE,  1'b0, 1'b0};
        vt[11] = '{A_ID,   1'b0, 32'h0, 4'hA, 32'h1, 1'b0, 1'b0};
        vt[12] = '{A_PEND, 1'b0, 32'h0, 4'h0, 32'hA, 1'b1, 1'b1};
        vt[13] = '{A_ID,   1'b0, 32'h0, 4'h0, 32'h1, 1'b1, 1'b1};
        vt[14] = '{A_PEND, 1'b1, 32'h2, 4'h0, 32'hA, 1'b0, 1'b1};
        vt[15] = '{A_ID,   1'b0, 32'h0, 4'h0, 32'h3, 1'b0, 1'b1};
        vt[16] = '{A_ID,   1'b0, 32'h0, 4'h0, 32'h3, 1'b0, 1'b0};
        vt[17] = '{A_ID,   1'b0, 32'h0, 4'h0, 32'h3, 1'b1, 1'b1};
        vt[18] = '{A_MASK, 1'b0, 32'h0, 4'h0, 32'hF, 1'b1, 1'b1};
        vt[19] = '{A_PEND, 1'b1, 32'h8, 4'h0, 32'h8, 1'b0, 1'b1};
        vt[20] = '{A_PEND, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1};
        vt[21] = '{A_PEND, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0};

        RST = 1'b1;
        bus(A_MASK, 1'b0, 32'h0, 4'h0);
        #1;
        check("reset intr", {31'b0, INTR}, 32'd0);
        check("reset busy", {31'b0, BUSY}, 32'd0);
        check("reset mask", IOBUS_IN, 32'd0);
        rd_chk("reset id", A_ID, NONE);
        step();
        RST = 1'b0;

        for (int i = 0; i < 22; i++) begin
            bus(vt[i].addr, vt[i].wr, vt[i].wdata, vt[i].src);
            #3;
            check($sformatf("vec%0d rd", i), IOBUS_IN, vt[i].exp_rd);
            check($sformatf("vec%0d intr", i), {31'b0, INTR},
                  {31'b0, vt[i].exp_intr});
            check($sformatf("vec%0d busy", i), {31'b0, BUSY},
                  {31'b0, vt[i].exp_busy});
            step();
        end

        // Masked source stays pending but silent; upper write bits ignored
        bus(A_MASK, 1'b1, 32'hFFFF_FFF0, 4'h0);
        step();
        bus(A_PEND, 1'b0, 32'h0, 4'h1);
        step();
        SRC = 4'h0;
        rd_chk("C pend", A_PEND, 32'h1);
        rd_chk("C mask", A_MASK, 32'h0);
        rd_chk("C id", A_ID, NONE);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("C quiet%0d", i), {31'b0, INTR}, 32'd0);
            step();
        end
        bus(A_MASK, 1'b1, 32'h1, 4'h0);
        step();
        IOBUS_WR = 1'b0;
        check("C edge1 intr", {31'b0, INTR}, 32'd0);
        step();
        check("C edge2 intr", {31'b0, INTR}, 32'd1);
        check("C edge2 busy", {31'b0, BUSY}, 32'd1);
        hi = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (INTR) hi++;
            else break;
        end
        check("C intr width", 32'(hi), 32'd2);
        bus(A_PEND, 1'b1, 32'h1, 4'h0);
        step();
        IOBUS_WR = 1'b0;
        step();
        check("C idle", {31'b0, BUSY}, 32'd0);
        check("C no repeat", {31'b0, INTR}, 32'd0);

        // Rise and clear on the same bit in the same cycle
        bus(A_MASK, 1'b1, 32'h0, 4'h0);
        step();
        bus(A_PEND, 1'b1, 32'h1, 4'h1);
        step();
        bus(A_PEND, 1'b0, 32'h0, 4'h0);
        rd_chk("D set wins", A_PEND, 32'h1);
        IOBUS_WR  = 1'b1;
        IOBUS_OUT = 32'h1;
        step();
        IOBUS_WR = 1'b0;
        rd_chk("D cleared", A_PEND, 32'h0);

        // A level held high sets pend only once
        bus(A_MASK, 1'b1, 32'h0, 4'h2);
        step();
        IOBUS_WR = 1'b0;
        step();
        step();
        rd_chk("E1 pend set", A_PEND, 32'h2);
        bus(A_PEND, 1'b1, 32'h2, 4'h2);
        step();
        IOBUS_WR = 1'b0;
        for (int i = 0; i < 14; i++) step();
        rd_chk("E1 held no reset", A_PEND, 32'h0);
        check("E1 no intr", {31'b0, INTR}, 32'd0);

        // Reset in the middle of ASSERT
        bus(A_MASK, 1'b1, 32'hF, 4'h0);
        step();
        bus(A_ID, 1'b0, 32'h0, 4'h2);
        step();
        step();
        check("E2 assert", {31'b0, INTR}, 32'd1);
        rd_chk("E2 id", A_ID, 32'h1);
        RST = 1'b1;
        SRC = 4'h0;
        #1;
        check("E2 rst intr", {31'b0, INTR}, 32'd0);
        check("E2 rst busy", {31'b0, BUSY}, 32'd0);
        rd_chk("E2 rst pend", A_PEND, 32'h0);
        rd_chk("E2 rst mask", A_MASK, 32'h0);
        step();
        RST = 1'b0;
        step();
        check("E2 after rst", {31'b0, INTR}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
